// File: rtl/arb_req_agent4_if.sv
`default_nettype none
// arb_req_agent4_if: shared output beat bus (valid/ready/last) from the agent to one sink.
// Revision: 1.0
interface arb_req_agent4_if #(
  parameter int DW = 8
);
  logic          valid;
  logic [1:0]    id;
  logic [DW-1:0] data;
  logic          last;
  logic          ready;

  modport master (output valid, output id, output data, output last, input ready);
  modport slave  (input valid, input id, input data, input last, output ready);
endinterface
`default_nettype wire

// File: rtl/arb_req_agent4.sv
`default_nettype none
// arb_req_agent4: per-channel burst command agent driving a 4-way round-robin arbiter
// and muxing the granted channel's beats onto one shared bus. Revision: 1.0
module arb_req_agent4 #(
  parameter int DW    = 8,
  parameter int LEN_W = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [3:0]           cmd_valid,
  output logic [3:0]           cmd_ready,
  input  logic [4*LEN_W-1:0]   cmd_len,
  input  logic [3:0]           ch_dvalid,
  input  logic [4*DW-1:0]      ch_data,
  output logic [3:0]           ch_dready,
  output logic [3:0]           arb_req,
  output logic                 arb_en,
  output logic [1:0]           cur_arb_id,
  input  logic [1:0]           nxt_arb_id,
  arb_req_agent4_if.master     bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARB  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  logic [1:0]       state;
  logic [3:0]       pend;
  logic [LEN_W-1:0] len_q [4];
  logic [1:0]       owner;
  logic [LEN_W-1:0] beat_cnt;

  logic             in_xfer;
  logic             beat_hs;
  logic             last_hs;
  logic [3:0]       cmd_hs;

  assign in_xfer   = (state == ST_XFER);
  assign cmd_ready = ~pend;
  assign arb_req   = pend;
  assign arb_en    = (state == ST_ARB);
  assign cmd_hs    = cmd_valid & ~pend;

  // Data path is combinational from the owner; id and last come from registers only.
  assign bus.valid = in_xfer & ch_dvalid[owner];
  assign bus.data  = ch_data[owner*DW +: DW];
  assign bus.id    = owner;
  assign bus.last  = in_xfer & (beat_cnt == len_q[owner]);
  assign ch_dready = {4{in_xfer & bus.ready}} & (4'b0001 << owner);

  assign beat_hs   = bus.valid & bus.ready;
  assign last_hs   = beat_hs & bus.last;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pend <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        len_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cmd_hs[i]) begin
          pend[i]  <= 1'b1;
          len_q[i] <= cmd_len[i*LEN_W +: LEN_W];
        end else if (last_hs && (owner == 2'(i))) begin
          pend[i]  <= 1'b0;
        end
      end
    end
  end

  // cur_arb_id survives IDLE so the rotation continues across bursts.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      owner      <= 2'd0;
      cur_arb_id <= 2'd3;
      beat_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pend) begin
            state <= ST_ARB;
          end
        end
        ST_ARB: begin
          owner      <= nxt_arb_id;
          cur_arb_id <= nxt_arb_id;
          beat_cnt   <= '0;
          state      <= ST_XFER;
        end
        ST_XFER: begin
          if (last_hs) begin
            state <= ST_IDLE;
          end else if (beat_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arb_req_agent4.sv
`default_nettype none
// tb_arb_req_agent4: table-driven and hand-sequenced bench with per-channel beat scoreboard.
// Revision: 1.0
module tb_arb_req_agent4;

  logic        clk;
  logic        rst;
  logic [3:0]  cmd_valid;
  logic [3:0]  cmd_ready;
  logic [15:0] cmd_len;
  logic [3:0]  ch_dvalid;
  logic [31:0] ch_data;
  logic [3:0]  ch_dready;
  logic [3:0]  arb_req;
  logic        arb_en;
  logic [1:0]  cur_arb_id;
  logic [1:0]  nxt_arb_id;

  arb_req_agent4_if #(.DW(8)) bus_if ();

  arb_req_agent4 #(.DW(8), .LEN_W(4)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .ch_dvalid  (ch_dvalid),
    .ch_data    (ch_data),
    .ch_dready  (ch_dready),
    .arb_req    (arb_req),
    .arb_en     (arb_en),
    .cur_arb_id (cur_arb_id),
    .nxt_arb_id (nxt_arb_id),
    .bus        (bus_if)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] lens;
    int          n;
    logic [7:0]  ord;
    logic [31:0] starts;
    logic [1:0]  cur_end;
  } vec_t;

  int          errs = 0;
  int          checks = 0;
  int          cyc = 0;
  int          base = 0;
  int          req_cnt [4];
  logic [3:0]  req_len [4];
  logic [5:0]  seq [4];
  int          bcnt [4];
  int          burst_beat = 0;
  beat_t       exp_q [4][$];
  logic [1:0]  grant_log [$];
  int          start_log [$];
  beat_t       mon_e;
  vec_t        vecs [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Round-robin arbiter: first requester after cur, cur itself lowest.
  function automatic logic [1:0] rr_pick(input logic [1:0] cur, input logic [3:0] req);
    logic [1:0] idx;
    rr_pick = cur;
    for (int k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  always_comb nxt_arb_id = rr_pick(cur_arb_id, arb_req);

  always_comb begin
    ch_data = '0;
    for (int i = 0; i < 4; i++) ch_data[i*8 +: 8] = {2'(i), seq[i]};
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ch_dvalid[i] && ch_dready[i]) seq[i] <= seq[i] + 6'd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Command driver: issues queued commands whenever the channel is ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (!rst && req_cnt[i] > 0 && cmd_ready[i]) begin
          cmd_valid[i] = 1'b1;
          cmd_len[i*4 +: 4] = req_len[i];
          for (int k = 0; k <= int'(req_len[i]); k++)
            exp_q[i].push_back({2'(i), 6'(seq[i] + 6'(k)), (k == int'(req_len[i]))});
          req_cnt[i]--;
        end else begin
          cmd_valid[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (arb_en) begin
        grant_log.push_back(nxt_arb_id);
        burst_beat = 0;
      end
      if (bus_if.valid && bus_if.ready) begin
        if (burst_beat == 0) start_log.push_back(cyc - base);
        burst_beat++;
        bcnt[bus_if.id]++;
        chk("beat_dready", 32'(ch_dready), 32'(4'b0001 << bus_if.id));
        chk("beat_expected", 32'(exp_q[bus_if.id].size() != 0), 32'd1);
        if (exp_q[bus_if.id].size() != 0) begin
          mon_e = exp_q[bus_if.id].pop_front();
          chk("beat_data", 32'(bus_if.data), 32'(mon_e.d));
          chk("beat_last", 32'(bus_if.last), 32'(mon_e.l));
        end
      end
    end
  end

  task automatic to_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int limit);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy) begin
      @(posedge clk);
      #2;
      busy = (arb_req != 4'b0) || bus_if.valid;
      for (int i = 0; i < 4; i++) busy = busy || (req_cnt[i] > 0) || (exp_q[i].size() != 0);
      n++;
      if (busy && n > limit) begin
        chk("wait_done_timeout", 32'(n), 32'(limit));
        busy = 1'b0;
      end
    end
  endtask

  task automatic request(input int ch, input logic [3:0] len);
    req_len[ch] = len;
    req_cnt[ch] = 1;
  endtask

  initial begin
    logic [7:0]  arb_bits, rdy_bits, val_bits, last_bits;
    logic [7:0]  held_data;
    logic [1:0]  fair_exp [5];
    int          b0;

    rst = 1'b1;
    cmd_valid = 4'b0;
    cmd_len = '0;
    ch_dvalid = 4'hF;
    bus_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_cnt[i] = 0;
      req_len[i] = 4'd0;
      seq[i] = 6'(i * 8);
      bcnt[i] = 0;
    end

    vecs[0] = '{4'hF, 16'h0000, 4, 8'hE4, 32'h0C09_0603, 2'd3};
    vecs[1] = '{4'hA, 16'h1020, 2, 8'h0D, 32'h0000_0803, 2'd3};
    vecs[2] = '{4'h5, 16'h0301, 2, 8'h08, 32'h0000_0703, 2'd2};
    vecs[3] = '{4'h9, 16'h0000, 2, 8'h03, 32'h0000_0603, 2'd0};
    vecs[4] = '{4'h3, 16'h0020, 2, 8'h01, 32'h0000_0803, 2'd0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'hF);
    chk("rst_arb_req", 32'(arb_req), 32'h0);
    chk("rst_arb_en", 32'(arb_en), 32'h0);
    chk("rst_cur_arb_id", 32'(cur_arb_id), 32'h3);
    chk("rst_bus_valid", 32'(bus_if.valid), 32'h0);
    chk("rst_bus_last", 32'(bus_if.last), 32'h0);
    chk("rst_bus_id", 32'(bus_if.id), 32'h0);
    chk("rst_ch_dready", 32'(ch_dready), 32'h0);

    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      grant_log.delete();
      start_log.delete();
      base = cyc + 1;
      for (int i = 0; i < 4; i++)
        if (vecs[v].mask[i]) request(i, vecs[v].lens[i*4 +: 4]);
      wait_done(200);
      chk("vec_grant_count", 32'(grant_log.size()), 32'(vecs[v].n));
      for (int k = 0; k < vecs[v].n && k < grant_log.size() && k < start_log.size(); k++) begin
        chk("vec_grant_order", 32'(grant_log[k]), 32'(vecs[v].ord[k*2 +: 2]));
        chk("vec_first_beat_cycle", 32'(start_log[k]), 32'(vecs[v].starts[k*8 +: 8]));
      end
      chk("vec_cur_arb_id", 32'(cur_arb_id), 32'(vecs[v].cur_end));
    end

    // Single ch1 burst of 3 beats: cycle-exact profile.
    @(negedge clk);
    base = cyc + 1;
    request(1, 4'd2);
    @(posedge clk);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      arb_bits[c]  = arb_en;
      rdy_bits[c]  = cmd_ready[1];
      val_bits[c]  = bus_if.valid;
      last_bits[c] = bus_if.last;
    end
    chk("single_arb_en", 32'(arb_bits), 32'h04);
    chk("single_cmd_ready1", 32'(rdy_bits), 32'hC1);
    chk("single_bus_valid", 32'(val_bits), 32'h38);
    chk("single_bus_last", 32'(last_bits), 32'h20);
    wait_done(50);
    chk("single_cur_arb_id", 32'(cur_arb_id), 32'h1);

    // Fairness: ch0 re-issues three times while ch2 keeps one pending.
    @(negedge clk);
    grant_log.delete();
    fair_exp = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd0};
    req_len[0] = 4'd0; req_len[2] = 4'd0;
    req_cnt[0] = 3;    req_cnt[2] = 2;
    wait_done(300);
    chk("fair_grant_count", 32'(grant_log.size()), 32'd5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      chk("fair_grant_order", 32'(grant_log[k]), 32'(fair_exp[k]));

    // Sink backpressure in the middle of a 4-beat ch3 burst.
    @(negedge clk);
    base = cyc + 1;
    b0 = bcnt[3];
    request(3, 4'd3);
    to_cycle(base + 5);
    bus_if.ready = 1'b0;
    @(negedge clk);
    held_data = bus_if.data;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_data_stable", 32'(bus_if.data), 32'(held_data));
      chk("stall_id", 32'(bus_if.id), 32'd3);
      chk("stall_dready", 32'(ch_dready), 32'h0);
    end
    to_cycle(base + 8);
    bus_if.ready = 1'b1;
    wait_done(100);
    chk("stall_beats", 32'(bcnt[3] - b0), 32'd4);

    // Source stall: ch0 data valid drops for two cycles.
    @(negedge clk);
    base = cyc + 1;
    b0 = bcnt[0];
    request(0, 4'd3);
    to_cycle(base + 5);
    ch_dvalid[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("src_stall_valid", 32'(bus_if.valid), 32'h0);
      chk("src_stall_last", 32'(bus_if.last), 32'h0);
    end
    to_cycle(base + 7);
    ch_dvalid[0] = 1'b1;
    wait_done(100);
    chk("src_stall_beats", 32'(bcnt[0] - b0), 32'd4);

    // Reset after two beats of a 5-beat ch2 burst.
    @(negedge clk);
    base = cyc + 1;
    request(2, 4'd4);
    to_cycle(base + 5);
    rst = 1'b1;
    #1;
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'hF);
    chk("midrst_cur_arb_id", 32'(cur_arb_id), 32'h3);
    chk("midrst_bus_valid", 32'(bus_if.valid), 32'h0);
    chk("midrst_bus_last", 32'(bus_if.last), 32'h0);
    chk("midrst_dready", 32'(ch_dready), 32'h0);
    chk("midrst_arb_en", 32'(arb_en), 32'h0);
    chk("midrst_dropped_beats", 32'(exp_q[2].size()), 32'd3);
    exp_q[2].delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    grant_log.delete();
    b0 = bcnt[2];
    request(2, 4'd4);
    wait_done(100);
    chk("postrst_beats", 32'(bcnt[2] - b0), 32'd5);
    chk("postrst_grant_count", 32'(grant_log.size()), 32'd1);
    if (grant_log.size() > 0) chk("postrst_grant_id", 32'(grant_log[0]), 32'd2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
